// File: rtl/snes_reader.sv
// SNES controller port master: latches the pad, clocks out 16 serial bits, decodes 12 buttons.
// Latency: valid pulses 34*HALF_DIV cycles after the latch rise; one frame every POLL_CYCLES cycles.
// No backpressure: valid is a one-cycle strobe, and buttons/frame_err hold until the next frame.
module snes_reader #(
    parameter int HALF_DIV    = 12,
    parameter int POLL_CYCLES = 34667
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        en,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] buttons,
    output logic        valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PH_W = $clog2(2 * HALF_DIV);

    localparam logic [PW-1:0]   POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_DIV - 1);
    localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLK_LO,
        S_CLK_HI,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   poll_q;
    logic [PH_W-1:0] phase_q;
    logic [3:0]      bit_q;
    logic [15:0]     shift_q;
    logic            sync1_q, sync2_q;
    logic            latch_q, sclk_q, valid_q, err_q, busy_q;
    logic [11:0]     buttons_q;

    // Two-flop synchronizer for the asynchronous pad data; resets to the idle-high line level.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= snes_data;
            sync2_q <= sync1_q;
        end
    end

    // Free-running poll slot counter; a frame may only start while it reads zero.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            poll_q <= '0;
        end else if (poll_q == POLL_LAST) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_q + 1'b1;
        end
    end

    // Frame sequencer: all port-facing outputs are set on the transition into each state.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '1;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            buttons_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    latch_q <= 1'b0;
                    sclk_q  <= 1'b1;
                    valid_q <= 1'b0;
                    if (poll_q == '0 && en) begin
                        state_q <= S_LATCH;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        phase_q <= '0;
                    end
                end
                S_LATCH: begin
                    if (phase_q == LATCH_LAST) begin
                        state_q <= S_CLK_LO;
                        latch_q <= 1'b0;
                        sclk_q  <= 1'b0;
                        phase_q <= '0;
                        bit_q   <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_CLK_LO: begin
                    if (phase_q == HALF_LAST) begin
                        shift_q[bit_q] <= sync2_q;
                        state_q        <= S_CLK_HI;
                        sclk_q         <= 1'b1;
                        phase_q        <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_CLK_HI: begin
                    if (phase_q == HALF_LAST) begin
                        phase_q <= '0;
                        if (bit_q == 4'd15) begin
                            // Serial bits are active-low; bits 12-15 must read 1 on a standard pad.
                            state_q   <= S_DONE;
                            buttons_q <= ~shift_q[11:0];
                            err_q     <= ~&shift_q[15:12];
                            valid_q   <= 1'b1;
                        end else begin
                            state_q <= S_CLK_LO;
                            sclk_q  <= 1'b0;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    latch_q <= 1'b0;
                    sclk_q  <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign snes_latch = latch_q;
    assign snes_clk   = sclk_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_snes_reader.sv
// Bench for snes_reader: behavioural 4021-style pad, expected frames queued by stimulus,
// popped and compared by a monitor whenever valid fires; timing of latch/clk checked alongside.
module tb_snes_reader;

    localparam int HD    = 4;
    localparam int PC    = 200;
    localparam int FRAME = 34 * HD;

    logic        clk_i   = 1'b0;
    logic        reset_n = 1'b0;
    logic        en      = 1'b0;
    logic        snes_data;
    logic        snes_latch, snes_clk, valid, frame_err, busy;
    logic [11:0] buttons;

    snes_reader #(.HALF_DIV(HD), .POLL_CYCLES(PC)) dut (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .en         (en),
        .snes_data  (snes_data),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .buttons    (buttons),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_i = ~clk_i;

    // Pad model: parallel load on latch, shift on each serial clock rise, ones shifted in.
    logic [15:0] pad_word = 16'hFFFF;
    logic [15:0] pad_sr   = 16'hFFFF;
    always @(posedge snes_latch or posedge snes_clk) begin
        if (snes_latch) pad_sr = pad_word;
        else            pad_sr = {1'b1, pad_sr[15:1]};
    end
    assign snes_data = pad_sr[0];

    int cyc;
    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [11:0] b;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor state
    int  rise_cyc  = 0;
    int  rise_cnt  = 0;
    int  valid_cnt = 0;
    int  lat_run   = 0;
    int  lo_run    = 0;
    int  lo_pulses = 0;
    bit  in_frame  = 0;
    bit  illegal   = 0;
    bit  prev_latch = 0;
    bit  prev_clk   = 1;
    bit  prev_valid = 0;
    exp_t e;

    always @(negedge clk_i) begin
        if (!reset_n) begin
            in_frame   = 0;
            lat_run    = 0;
            lo_run     = 0;
            prev_latch = 0;
            prev_clk   = 1;
            prev_valid = 0;
        end else begin
            if (snes_latch && !prev_latch) begin
                rise_cyc  = cyc;
                rise_cnt++;
                in_frame  = 1;
                lo_pulses = 0;
                lat_run   = 0;
                illegal   = 0;
                check("busy_at_latch", int'(busy), 1);
            end
            if (snes_latch) begin
                lat_run++;
                if (!snes_clk) illegal = 1;
            end
            if (!snes_latch && prev_latch && in_frame) begin
                check("latch_width", lat_run, 2 * HD);
                check("clk_high_in_latch", int'(illegal), 0);
            end
            if (snes_clk) begin
                if (!prev_clk && in_frame) begin
                    check("clk_low_width", lo_run, HD);
                    lo_pulses++;
                end
                lo_run = 0;
            end else begin
                lo_run++;
            end
            if (prev_valid) begin
                check("valid_single", int'(valid), 0);
                check("busy_after_done", int'(busy), 0);
            end
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("buttons", int'(buttons), int'(e.b));
                    check("frame_err", int'(frame_err), int'(e.e));
                    check("frame_len", cyc - rise_cyc, FRAME);
                    check("clk_pulses", lo_pulses, 16);
                end
                valid_cnt++;
                in_frame = 0;
            end
            prev_latch = snes_latch;
            prev_clk   = snes_clk;
            prev_valid = valid;
        end
    end

    task automatic wait_valid(input string name);
        int start;
        int n;
        start = valid_cnt;
        n = 0;
        while (valid_cnt == start && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check({"valid_seen_", name}, int'(valid_cnt != start), 1);
    endtask

    task automatic wait_rise(input string name);
        int start;
        int n;
        start = rise_cnt;
        n = 0;
        while (rise_cnt == start && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check({"latch_seen_", name}, int'(rise_cnt != start), 1);
    endtask

    initial begin
        int r0;
        int n;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_latch", int'(snes_latch), 0);
        check("rst_clk", int'(snes_clk), 1);
        check("rst_buttons", int'(buttons), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);

        // Idle-high line: nothing pressed
        en       = 1'b1;
        pad_word = 16'hFFFF;
        exp_q.push_back({12'h000, 1'b0});
        reset_n  = 1'b1;
        @(negedge clk_i);
        check("latch_first_edge", int'(snes_latch), 1);
        wait_valid("idle_line");

        // Bits 0, 4, 11 low -> B, Up, R
        pad_word = 16'hF7EE;
        exp_q.push_back({12'h811, 1'b0});
        wait_rise("period");
        check("latch_period", rise_cyc - 1, PC);
        wait_valid("b_up_r");

        // Bit 13 low -> non-standard device
        pad_word = 16'hDFFF;
        exp_q.push_back({12'h000, 1'b1});
        wait_valid("bit13");

        // en low across a slot: no latch, outputs held
        en = 1'b0;
        r0 = rise_cnt;
        repeat (250) @(negedge clk_i);
        check("no_latch_en0", rise_cnt - r0, 0);
        check("held_buttons", int'(buttons), 0);
        check("held_ferr", int'(frame_err), 1);

        // en raised mid-period: frame waits for the counter wrap
        n = 0;
        while ((cyc % PC) != 100 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        en       = 1'b1;
        pad_word = ~16'h0001;
        exp_q.push_back({12'h001, 1'b0});
        wait_rise("en_raise");
        check("rise_on_slot", rise_cyc % PC, 1);
        // en dropped mid-frame: frame still completes
        repeat (50) @(negedge clk_i);
        en = 1'b0;
        wait_valid("en_drop");
        r0 = rise_cnt;
        repeat (250) @(negedge clk_i);
        check("no_latch_after_drop", rise_cnt - r0, 0);

        // Loopback: each button alone
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pad_word = ~(16'(1) << i);
            exp_q.push_back({12'(12'(1) << i), 1'b0});
            wait_valid("one_hot");
        end

        // Reset in the middle of bit 7; this frame must never report
        pad_word = 16'h0000;
        wait_rise("abort");
        repeat (8 + 8 * 7 + 2) @(posedge clk_i);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_clk", int'(snes_clk), 1);
        check("abort_latch", int'(snes_latch), 0);
        check("abort_buttons", int'(buttons), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        repeat (2) @(negedge clk_i);
        pad_word = ~16'h1100;
        exp_q.push_back({12'h100, 1'b1});
        reset_n  = 1'b1;
        @(negedge clk_i);
        check("latch_after_reset", int'(snes_latch), 1);
        wait_valid("after_reset");

        en = 1'b0;
        repeat (5) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/snes_reader.md
# snes_reader

Console-side SNES controller port master: generates the latch and serial clock, shifts in the 16-bit controller stream, and presents the 12 standard buttons as an active-high parallel word with a one-cycle valid strobe. It is the counterpart of our controller-emulation path (button decoder feeding the SNES recoder). It lets the FPGA poll a real SNES pad, or our own emulated pad in loopback, on the MachXO2 internal oscillator clock.

## Interface
Parameters:
- HALF_DIV, 12, system clocks per half serial-clock period; ≈6 µs at 2.08 MHz; legal ≥ 4
- POLL_CYCLES, 34667, system clocks from one latch rise to the next (≈60 Hz at 2.08 MHz); legal ≥ 34*HALF_DIV + 2

Ports:
- clk_i  in  1  system clock (internal oscillator)
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  polling enable; sampled only in IDLE
- snes_data  in  1  serial data from controller, active-low (0 = pressed), asynchronous
- snes_latch  out  1  latch pulse to controller, active-high
- snes_clk  out  1  serial clock to controller, idles high
- buttons  out  12  decoded buttons, active-high: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R
- valid  out  1  one-cycle strobe when buttons/frame_err update
- frame_err  out  1  1 if any of serial bits 12–15 read 0 (non-standard device)
- busy  out  1  high from LATCH through DONE

## Operation
- snes_data passes through a 2-flop synchronizer before use; all outputs are registered.
- Poll counter: free-running 0..POLL_CYCLES-1 and wraps; reset value 0.
- States: IDLE, LATCH, CLK_LO, CLK_HI, DONE. Phase counter counts 0..HALF_DIV-1; bit counter counts 0..15.
- IDLE: snes_latch=0, snes_clk=1. If poll counter == 0 and en=1, go to LATCH. Otherwise stay in IDLE and miss this slot; no catch-up.
- LATCH: snes_latch=1 for 2*HALF_DIV cycles, then go to CLK_LO with bit=0.
- CLK_LO: snes_clk=0 for HALF_DIV cycles. On the last cycle, shift the synchronized data into shift register bit [bit]. Then go to CLK_HI.
- CLK_HI: snes_clk=1 for HALF_DIV cycles. If bit==15, go to DONE; else bit+1 and go to CLK_LO.
- DONE (1 cycle):
  - buttons <= ~shift[11:0]
  - frame_err <= ~&shift[15:12]
  - valid=1
  - then go to IDLE
- buttons and frame_err hold between frames.
- Changes on en mid-frame have no effect; the frame completes.
- Reset mid-frame: all state returns to reset values at once, with no partial update of buttons.
- Floating or pulled-up line (no controller): reads all 1s, giving buttons=0 and frame_err=0.

## Timing
- Reset values: snes_latch=0, snes_clk=1, buttons=12'h000, valid=0, frame_err=0, busy=0, state IDLE.
- After reset release with en=1, snes_latch rises on the first clk_i edge (poll counter is 0).
- Frame length from latch rise to the valid cycle: 34*HALF_DIV cycles; valid is asserted in cycle 34*HALF_DIV.
- Bit n is sampled at latch rise + 2*HALF_DIV + 2*n*HALF_DIV + HALF_DIV - 1 cycles, i.e. the last cycle of low phase n. The sampled value is the pad level from 2 cycles earlier.
- Controller timing is assumed as follows: the pad drives bit 0 after latch falls and advances on each snes_clk rise. Data is stable for ≥ HALF_DIV-2 cycles before sampling.
- snes_latch and snes_clk are never low/high simultaneously in an illegal combination: snes_clk=1 throughout LATCH.
- Latch rises repeat every POLL_CYCLES cycles while en=1.

## Test plan
Use HALF_DIV=4, POLL_CYCLES=200 unless stated.
- Reset then en=1 with snes_data held 1 → latch high cycles 1–8; 16 low pulses of 4 cycles each; valid at cycle 136 with buttons=000, frame_err=0; next latch rise at cycle 200.
- Pad model drives serial pattern 0 on bits 0, 4, 11 only → buttons=12'h811, frame_err=0.
- Pad model drives bit 13 = 0, all else 1 → buttons=000, frame_err=1, valid still a single cycle.
- en=0 at poll slot → no latch and outputs held. en raised mid-period → frame starts only at the next counter wrap. en dropped mid-frame → frame completes with valid.
- reset_n asserted at bit 7 of a frame → snes_clk=1, snes_latch=0, buttons=000 immediately. After release, a fresh frame starts on the first edge.
- Loopback with the emulated pad, all 12 buttons pressed one at a time → buttons is one-hot at the matching index for each frame.
